// File: rtl/counter_mon_pkg.sv
// Shared types and defaults for the counter trend monitor.
// Optional build macro: MON_WRAP_EN (see step_classifier).
package counter_mon_pkg;

  localparam int DEF_WIDTH = 20;
  localparam int DEF_STEP  = 1;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_ARMED = 3'd1,
    PH_UP    = 3'd2,
    PH_DOWN  = 3'd3,
    PH_AGAIN = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_BAD  = 2'd3
  } step_e;

endpackage

// File: rtl/counter_trend_monitor_step_classifier.sv
// Combinational step classifier: sample - prev against +/-STEP.
// MON_WRAP_EN: evaluate delta modulo 2^WIDTH so max->min counts as an up step.
module step_classifier
  import counter_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic signed [WIDTH-1:0] sample,
  input  logic signed [WIDTH-1:0] prev,
  output step_e                   step_class
);

`ifdef MON_WRAP_EN
  // Truncated difference wraps naturally, giving modulo-2^WIDTH behaviour.
  localparam logic signed [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  logic signed [WIDTH-1:0] delta;
  assign delta = sample - prev;
`else
  localparam logic signed [WIDTH:0] STEP_V = (WIDTH+1)'(STEP);
  logic signed [WIDTH:0] delta;
  assign delta = {sample[WIDTH-1], sample} - {prev[WIDTH-1], prev};
`endif

  always_comb begin
    step_class = STEP_BAD;
    if (delta == '0)
      step_class = STEP_HOLD;
    else if (delta == STEP_V)
      step_class = STEP_UP;
    else if (delta == -STEP_V)
      step_class = STEP_DOWN;
  end

endmodule

// File: rtl/counter_trend_monitor.sv
// Trend monitor for a signed up/down counter: phase FSM, segment lengths, extrema, step errors.
// Optional build macro: MON_WRAP_EN (wrap-around steps treated as legal).
module counter_trend_monitor
  import counter_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] sample,
  output logic [2:0]              phase,
  output logic                    turn,
  output logic [CNT_W-1:0]        seg_len,
  output logic [CNT_W-1:0]        last_seg_len,
  output logic signed [WIDTH-1:0] peak,
  output logic signed [WIDTH-1:0] trough,
  output logic                    step_err,
  output logic [CNT_W-1:0]        err_index,
  output logic [CNT_W-1:0]        sample_idx
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  phase_e                  state, state_nxt;
  step_e                   cls;
  logic signed [WIDTH-1:0] prev;
  logic                    turn_nxt, err_nxt;
  logic [CNT_W-1:0]        seg_nxt, last_nxt, eidx_nxt;

  step_classifier #(.WIDTH(WIDTH), .STEP(STEP)) u_cls (
    .sample     (sample),
    .prev       (prev),
    .step_class (cls)
  );

  assign phase = state;

  always_comb begin
    state_nxt = state;
    turn_nxt  = 1'b0;
    seg_nxt   = seg_len;
    last_nxt  = last_seg_len;
    err_nxt   = step_err;
    eidx_nxt  = err_index;
    if (sample_valid) begin
      if (state == PH_IDLE) begin
        state_nxt = PH_ARMED;
      end else begin
        case (cls)
          STEP_UP: begin
            case (state)
              PH_ARMED: begin state_nxt = PH_UP; seg_nxt = CNT_W'(1); end
              PH_DOWN: begin
                state_nxt = PH_AGAIN;
                turn_nxt  = 1'b1;
                last_nxt  = seg_len;
                seg_nxt   = CNT_W'(1);
              end
              PH_UP, PH_AGAIN: seg_nxt = sat_inc(seg_len);
              default: ;
            endcase
          end
          STEP_DOWN: begin
            case (state)
              PH_ARMED: begin state_nxt = PH_DOWN; seg_nxt = CNT_W'(1); end
              PH_UP, PH_AGAIN: begin
                state_nxt = PH_DOWN;
                turn_nxt  = 1'b1;
                last_nxt  = seg_len;
                seg_nxt   = CNT_W'(1);
              end
              PH_DOWN: seg_nxt = sat_inc(seg_len);
              default: ;
            endcase
          end
          // Only the first illegal step is recorded; the phase is left alone.
          STEP_BAD: begin
            if (!step_err) begin
              err_nxt  = 1'b1;
              eidx_nxt = sample_idx;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= PH_IDLE;
      turn         <= 1'b0;
      seg_len      <= '0;
      last_seg_len <= '0;
      peak         <= '0;
      trough       <= '0;
      step_err     <= 1'b0;
      err_index    <= '0;
      sample_idx   <= '0;
      prev         <= '0;
    end else begin
      state        <= state_nxt;
      turn         <= turn_nxt;
      seg_len      <= seg_nxt;
      last_seg_len <= last_nxt;
      step_err     <= err_nxt;
      err_index    <= eidx_nxt;
      if (sample_valid) begin
        prev       <= sample;
        sample_idx <= sat_inc(sample_idx);
        // The first sample after reset seeds the extrema rather than comparing against zero.
        if (state == PH_IDLE) begin
          peak   <= sample;
          trough <= sample;
        end else begin
          if (sample > peak)   peak   <= sample;
          if (sample < trough) trough <= sample;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_trend_monitor.sv
// Directed self-checking bench for counter_trend_monitor (default parameters).
module tb_counter_trend_monitor;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                sample_valid = 1'b0;
  logic signed [19:0]  sample = '0;
  logic [2:0]          phase;
  logic                turn;
  logic [15:0]         seg_len, last_seg_len, err_index, sample_idx;
  logic signed [19:0]  peak, trough;
  logic                step_err;

  int ncmp  = 0;
  int nfail = 0;

  counter_trend_monitor #(.WIDTH(20), .STEP(1), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .phase        (phase),
    .turn         (turn),
    .seg_len      (seg_len),
    .last_seg_len (last_seg_len),
    .peak         (peak),
    .trough       (trough),
    .step_err     (step_err),
    .err_index    (err_index),
    .sample_idx   (sample_idx)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input int s);
    @(negedge clk);
    sample_valid = v;
    sample       = 20'(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    ncmp++; if (phase !== 3'd0) begin nfail++; $display("FAIL rst_phase: got %0d want 0", phase); end
    ncmp++; if (turn !== 1'b0 || step_err !== 1'b0) begin nfail++; $display("FAIL rst_flags: turn %0b err %0b want 0 0", turn, step_err); end
    ncmp++; if (seg_len !== 16'd0 || last_seg_len !== 16'd0 || sample_idx !== 16'd0 || err_index !== 16'd0)
      begin nfail++; $display("FAIL rst_cnt: seg %0d last %0d idx %0d eidx %0d want 0", seg_len, last_seg_len, sample_idx, err_index); end
    ncmp++; if (peak !== 20'sd0 || trough !== 20'sd0) begin nfail++; $display("FAIL rst_ext: peak %0d trough %0d want 0", peak, trough); end
  endtask

  task automatic test_count_up();
    do_reset();
    drive(1'b1, 0);
    ncmp++; if (phase !== 3'd1) begin nfail++; $display("FAIL cu_armed: got %0d want 1", phase); end
    drive(1'b1, 1);
    ncmp++; if (phase !== 3'd2 || seg_len !== 16'd1) begin nfail++; $display("FAIL cu_up1: phase %0d seg %0d want 2 1", phase, seg_len); end
    for (int i = 2; i <= 526; i++) drive(1'b1, i);
    ncmp++; if (seg_len !== 16'd526) begin nfail++; $display("FAIL cu_seg: got %0d want 526", seg_len); end
    ncmp++; if (peak !== 20'sd526 || trough !== 20'sd0) begin nfail++; $display("FAIL cu_ext: peak %0d trough %0d want 526 0", peak, trough); end
    ncmp++; if (step_err !== 1'b0 || sample_idx !== 16'd527) begin nfail++; $display("FAIL cu_idx: err %0b idx %0d want 0 527", step_err, sample_idx); end
  endtask

  task automatic test_count_down();
    int turns = 0;
    drive(1'b1, 525);
    ncmp++; if (turn !== 1'b1 || phase !== 3'd3) begin nfail++; $display("FAIL cd_turn: turn %0b phase %0d want 1 3", turn, phase); end
    ncmp++; if (last_seg_len !== 16'd526 || seg_len !== 16'd1) begin nfail++; $display("FAIL cd_last: last %0d seg %0d want 526 1", last_seg_len, seg_len); end
    for (int v = 524; v >= -80; v--) begin
      drive(1'b1, v);
      if (turn) turns++;
    end
    ncmp++; if (turns !== 0) begin nfail++; $display("FAIL cd_extra_turns: got %0d want 0", turns); end
    ncmp++; if (phase !== 3'd3 || seg_len !== 16'd606) begin nfail++; $display("FAIL cd_seg: phase %0d seg %0d want 3 606", phase, seg_len); end
    ncmp++; if (trough !== -20'sd80 || peak !== 20'sd526) begin nfail++; $display("FAIL cd_ext: trough %0d peak %0d want -80 526", trough, peak); end
  endtask

  task automatic test_count_again();
    drive(1'b1, -79);
    ncmp++; if (turn !== 1'b1 || phase !== 3'd4) begin nfail++; $display("FAIL ca_turn: turn %0b phase %0d want 1 4", turn, phase); end
    ncmp++; if (last_seg_len !== 16'd606 || seg_len !== 16'd1) begin nfail++; $display("FAIL ca_seg: last %0d seg %0d want 606 1", last_seg_len, seg_len); end
    drive(1'b1, -78);
    ncmp++; if (turn !== 1'b0 || seg_len !== 16'd2 || phase !== 3'd4) begin nfail++; $display("FAIL ca_cont: turn %0b seg %0d phase %0d want 0 2 4", turn, seg_len, phase); end
    drive(1'b1, -79);
    ncmp++; if (turn !== 1'b1 || phase !== 3'd3 || last_seg_len !== 16'd2) begin nfail++; $display("FAIL ca_back: turn %0b phase %0d last %0d want 1 3 2", turn, phase, last_seg_len); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 5);
    drive(1'b1, 6);
    drive(1'b1, 8);
    ncmp++; if (step_err !== 1'b1 || err_index !== 16'd2) begin nfail++; $display("FAIL il_first: err %0b eidx %0d want 1 2", step_err, err_index); end
    drive(1'b1, 9);
    ncmp++; if (seg_len !== 16'd2) begin nfail++; $display("FAIL il_resync: seg %0d want 2", seg_len); end
    drive(1'b1, 12);
    ncmp++; if (err_index !== 16'd2 || step_err !== 1'b1 || phase !== 3'd2) begin nfail++; $display("FAIL il_sticky: eidx %0d err %0b phase %0d want 2 1 2", err_index, step_err, phase); end
    ncmp++; if (peak !== 20'sd12 || trough !== 20'sd5 || sample_idx !== 16'd5) begin nfail++; $display("FAIL il_ext: peak %0d trough %0d idx %0d want 12 5 5", peak, trough, sample_idx); end
  endtask

  task automatic test_hold_gaps();
    do_reset();
    drive(1'b1, 3);
    for (int i = 0; i < 3; i++) drive(1'b0, 77);
    ncmp++; if (sample_idx !== 16'd1 || turn !== 1'b0 || peak !== 20'sd3) begin nfail++; $display("FAIL hg_gap: idx %0d turn %0b peak %0d want 1 0 3", sample_idx, turn, peak); end
    drive(1'b1, 3);
    ncmp++; if (phase !== 3'd1 || seg_len !== 16'd0) begin nfail++; $display("FAIL hg_hold: phase %0d seg %0d want 1 0", phase, seg_len); end
    for (int i = 0; i < 3; i++) drive(1'b0, -9);
    drive(1'b1, 4);
    ncmp++; if (phase !== 3'd2 || seg_len !== 16'd1 || step_err !== 1'b0) begin nfail++; $display("FAIL hg_up: phase %0d seg %0d err %0b want 2 1 0", phase, seg_len, step_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 10);
    drive(1'b1, 11);
    drive(1'b1, 12);
    ncmp++; if (phase !== 3'd2) begin nfail++; $display("FAIL ar_pre: phase %0d want 2", phase); end
    #2 rst = 1'b0;
    #1;
    ncmp++; if (phase !== 3'd0 || seg_len !== 16'd0 || sample_idx !== 16'd0 || peak !== 20'sd0 || trough !== 20'sd0)
      begin nfail++; $display("FAIL ar_async: phase %0d seg %0d idx %0d peak %0d trough %0d want 0", phase, seg_len, sample_idx, peak, trough); end
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b1;
    drive(1'b1, 100);
    ncmp++; if (phase !== 3'd1 || peak !== 20'sd100 || trough !== 20'sd100 || sample_idx !== 16'd1)
      begin nfail++; $display("FAIL ar_first: phase %0d peak %0d trough %0d idx %0d want 1 100 100 1", phase, peak, trough, sample_idx); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 524287);
    drive(1'b1, -524288);
`ifdef MON_WRAP_EN
    ncmp++; if (step_err !== 1'b0 || phase !== 3'd2) begin nfail++; $display("FAIL wr_up: err %0b phase %0d want 0 2", step_err, phase); end
`else
    ncmp++; if (step_err !== 1'b1 || err_index !== 16'd1 || phase !== 3'd1) begin nfail++; $display("FAIL wr_bad: err %0b eidx %0d phase %0d want 1 1 1", step_err, err_index, phase); end
`endif
    ncmp++; if (peak !== 20'sd524287 || trough !== -20'sd524288) begin nfail++; $display("FAIL wr_ext: peak %0d trough %0d want 524287 -524288", peak, trough); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_count_again();
    test_illegal();
    test_hold_gaps();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
